// File: rtl/fifo_pkg.sv
// Shared defaults and the log2 helper for the parameterised FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 6;
    localparam int unsigned FIFO_DEPTH      = 4;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned log2c(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port with async-cleared output.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = log2c(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage is intentionally left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) rd_data_q <= '0;
        else          rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with runtime almost-full/almost-empty thresholds.
// Define FIFO_STICKY_ERR_EN to hold Fifo_Error until reset instead of pulsing it.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned CNT_WIDTH  = log2c(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic [CNT_WIDTH-1:0]  Almost_Full_thr,
    input  logic [CNT_WIDTH-1:0]  Almost_Empty_thr,
    output logic [DATA_WIDTH-1:0] Fifo_Data_out,
    output logic                  Fifo_Valid,
    output logic                  Fifo_Empty,
    output logic                  Fifo_Full,
    output logic                  Pausa,
    output logic                  Almost_Empty,
    output logic                  Fifo_Error,
    output logic [CNT_WIDTH-1:0]  Fifo_Count
);

    localparam int unsigned PTR_WIDTH = log2c(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 push_ok, pop_ok, err_event;

    // A pop on empty is never rescued by a same-cycle push; a push on full needs a real pop.
    always_comb begin
        pop_ok    = pop && (cnt_q != '0);
        push_ok   = push && ((cnt_q < CNT_WIDTH'(DEPTH)) || pop_ok);
        err_event = (push && !push_ok) || (pop && !pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = pop_ok;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);

        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase

`ifdef FIFO_STICKY_ERR_EN
        err_d = err_q || err_event;
`else
        err_d = err_event;
`endif
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (Fifo_Data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (Fifo_Data_out)
    );

    assign Fifo_Valid   = valid_q;
    assign Fifo_Error   = err_q;
    assign Fifo_Count   = cnt_q;
    assign Fifo_Empty   = (cnt_q == '0);
    assign Fifo_Full    = (cnt_q == CNT_WIDTH'(DEPTH));
    assign Pausa        = (cnt_q >= Almost_Full_thr);
    assign Almost_Empty = (cnt_q <= Almost_Empty_thr);

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;

`ifdef FIFO_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [5:0] din = '0;
    logic [2:0] af_thr = 3'd3;
    logic [2:0] ae_thr = 3'd1;
    logic [5:0] dout;
    logic       valid, empty, full, pausa, aempty, err;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    fifo_param dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .push             (push),
        .pop              (pop),
        .Fifo_Data_in     (din),
        .Almost_Full_thr  (af_thr),
        .Almost_Empty_thr (ae_thr),
        .Fifo_Data_out    (dout),
        .Fifo_Valid       (valid),
        .Fifo_Empty       (empty),
        .Fifo_Full        (full),
        .Pausa            (pausa),
        .Almost_Empty     (aempty),
        .Fifo_Error       (err),
        .Fifo_Count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic ps, input logic pp, input logic [5:0] d);
        push = ps;
        pop  = pp;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_word;

        #2;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full",  8'(full),  8'd0);
        chk("rst_ae",    8'(aempty), 8'd1);
        chk("rst_pausa", 8'(pausa), 8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        chk("rst_err",   8'(err),   8'd0);
        chk("rst_dout",  8'(dout),  8'h00);
        reset_L = 1'b1;

        // Fill to full
        cyc(1, 0, 6'h11);
        chk("p1_count", 8'(count), 8'd1);
        chk("p1_ae",    8'(aempty), 8'd1);
        chk("p1_pausa", 8'(pausa), 8'd0);
        cyc(1, 0, 6'h16);
        chk("p2_count", 8'(count), 8'd2);
        chk("p2_ae",    8'(aempty), 8'd0);
        chk("p2_pausa", 8'(pausa), 8'd0);
        cyc(1, 0, 6'h30);
        chk("p3_count", 8'(count), 8'd3);
        chk("p3_pausa", 8'(pausa), 8'd1);
        chk("p3_full",  8'(full),  8'd0);
        cyc(1, 0, 6'h1C);
        chk("p4_count", 8'(count), 8'd4);
        chk("p4_full",  8'(full),  8'd1);
        chk("p4_err",   8'(err),   8'd0);

        // Overflow: dropped push
        cyc(1, 0, 6'h2A);
        chk("ovf_count", 8'(count), 8'd4);
        chk("ovf_err",   8'(err),   8'd1);
        chk("ovf_valid", 8'(valid), 8'd0);
        cyc(0, 0, 6'h00);
        chk("ovf_err_after", 8'(err), 8'(STICKY));

        // Pop three in order
        cyc(0, 1, 6'h00);
        chk("pop1_dout",  8'(dout),  8'h11);
        chk("pop1_valid", 8'(valid), 8'd1);
        cyc(0, 1, 6'h00);
        chk("pop2_dout",  8'(dout),  8'h16);
        chk("pop2_valid", 8'(valid), 8'd1);
        cyc(0, 1, 6'h00);
        chk("pop3_dout",  8'(dout),  8'h30);
        chk("pop3_valid", 8'(valid), 8'd1);
        chk("pop3_count", 8'(count), 8'd1);
        chk("pop3_ae",    8'(aempty), 8'd1);
        cyc(0, 0, 6'h00);
        chk("idle_valid", 8'(valid), 8'd0);
        chk("idle_dout",  8'(dout),  8'h30);
        cyc(0, 1, 6'h00);
        chk("pop4_dout",  8'(dout),  8'h1C);
        chk("pop4_empty", 8'(empty), 8'd1);

        // Push + pop on empty: pop rejected
        cyc(1, 1, 6'h1A);
        chk("pe_count", 8'(count), 8'd1);
        chk("pe_err",   8'(err),   8'd1);
        chk("pe_valid", 8'(valid), 8'd0);
        cyc(0, 1, 6'h00);
        chk("pe_dout",  8'(dout),  8'h1A);
        chk("pe_vpop",  8'(valid), 8'd1);
        chk("pe_err_after", 8'(err), 8'(STICKY));

        // Full with simultaneous push/pop, wrapping pointers over 8 words
        for (int i = 0; i < 4; i++) cyc(1, 0, 6'(8'h20 + i));
        chk("wrap_fill", 8'(count), 8'd4);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 6'(8'h1B + i));
            exp_word = (i < 4) ? 6'(8'h20 + i) : 6'(8'h1B + i - 4);
            chk($sformatf("wrap%0d_dout", i), 8'(dout), 8'(exp_word));
            chk($sformatf("wrap%0d_count", i), 8'(count), 8'd4);
        end
        chk("wrap_err", 8'(err), 8'(STICKY));

        // Out-of-range threshold: never reached
        af_thr = 3'd5;
        #1;
        chk("af5_pausa", 8'(pausa), 8'd0);
        af_thr = 3'd3;

        // Asynchronous reset mid-cycle with count 3
        cyc(0, 1, 6'h00);
        chk("pre_rst_dout",  8'(dout),  8'h1F);
        chk("pre_rst_count", 8'(count), 8'd3);
        #2;
        reset_L = 1'b0;
        #1;
        chk("ar_count", 8'(count), 8'd0);
        chk("ar_empty", 8'(empty), 8'd1);
        chk("ar_dout",  8'(dout),  8'h00);
        chk("ar_valid", 8'(valid), 8'd0);
        chk("ar_err",   8'(err),   8'd0);
        chk("ar_ae",    8'(aempty), 8'd1);
        af_thr = 3'd0;
        #1;
        chk("ar_pausa_thr0", 8'(pausa), 8'd1);
        af_thr = 3'd3;
        #1;
        reset_L = 1'b1;

        // First post-reset pop underflows
        cyc(0, 1, 6'h00);
        chk("post_err",   8'(err),   8'd1);
        chk("post_valid", 8'(valid), 8'd0);
        chk("post_count", 8'(count), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
